div4_req_stage: RTL and testbench

- Upstream issue/capture stage wrapped around the combinational 4-bit integer divider (X/D -> Q/R).
- Buffers divide requests from a valid/ready producer in a small FIFO and presents the head operands to the divider.
- Registers the divider's Q/R into an output slot with its own valid/ready handshake.
- Short-circuits divide-by-zero and flags it.

---
 rtl/div4_req_stage.sv | 106 ++++++++++
 tb/tb_div4_req_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div4_req_stage.sv
// Request FIFO and registered result slot around a combinational 4-bit divider.
// Zero divisors bypass the divider and are flagged on the result.
module div4_req_stage #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_x,
    input  logic [3:0]       req_d,
    output logic [3:0]       div_x,
    output logic [3:0]       div_d,
    input  logic [3:0]       div_q,
    input  logic [3:0]       div_r,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_q,
    output logic [3:0]       res_r,
    output logic             res_dz,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [3:0]       mem_x [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             not_empty;
    logic             cap;
    logic             push;
    logic             pop;
    logic [3:0]       head_x;
    logic [3:0]       head_d;

    assign not_empty = (occupancy != '0);
    assign req_ready = (occupancy != FULL);
    assign cap       = not_empty & (~res_valid | res_ready);
    assign push      = req_valid & req_ready & ~clr;
    assign pop       = cap & ~clr;

    assign head_x = mem_x[rptr];
    assign head_d = mem_d[rptr];
    assign div_x  = not_empty ? head_x : '0;
    assign div_d  = not_empty ? head_d : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x[i] <= '0;
                mem_d[i] <= '0;
            end
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem_x[wptr] <= req_x;
                mem_d[wptr] <= req_d;
                wptr        <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // q/r keep their last value through drain and flush; only valid/dz clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_q     <= '0;
            res_r     <= '0;
            res_dz    <= 1'b0;
        end else if (clr) begin
            res_valid <= 1'b0;
            res_dz    <= 1'b0;
        end else if (cap) begin
            res_valid <= 1'b1;
            if (head_d == 4'd0) begin
                res_q  <= 4'hF;
                res_r  <= head_x;
                res_dz <= 1'b1;
            end else begin
                res_q  <= div_q;
                res_r  <= div_r;
                res_dz <= 1'b0;
            end
        end else if (res_valid & res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div4_req_stage.sv
// Directed bench for div4_req_stage with a behavioural divider on the div_* side.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div4_req_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_x;
    logic [3:0] req_d;
    logic [3:0] div_x;
    logic [3:0] div_d;
    logic [3:0] div_q;
    logic [3:0] div_r;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_q;
    logic [3:0] res_r;
    logic       res_dz;
    logic [1:0] occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign div_q = (div_d == 4'd0) ? 4'd0 : div_x / div_d;
    assign div_r = (div_d == 4'd0) ? 4'd0 : div_x % div_d;

    div4_req_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_d(req_d),
        .div_x(div_x), .div_d(div_d),
        .div_q(div_q), .div_r(div_r),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_r(res_r), .res_dz(res_dz),
        .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] x,
                         input logic [3:0] d, input logic rr);
        @(negedge clk);
        req_valid = v;
        req_x     = x;
        req_d     = d;
        res_ready = rr;
    endtask

    task automatic res(input string tag, input logic [3:0] q,
                       input logic [3:0] r, input logic dz);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_q"}, res_q, q);
        check({tag, "_r"}, res_r, r);
        check({tag, "_dz"}, res_dz, dz);
    endtask

    // three requests with the slot stalled: one held result, FIFO full
    task automatic fill(input logic [3:0] x0, input logic [3:0] d0);
        drive(1, x0, d0, 0);
        drive(1, 10, 3, 0);
        drive(1, 11, 2, 0);
        drive(0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; clr = 0; req_valid = 0; req_x = 0; req_d = 0;
        res_ready = 0;
        #12;
        check("rst_occ", occupancy, 0);
        check("rst_rv", res_valid, 0);
        check("rst_rdy", req_ready, 1);
        check("rst_divx", div_x, 0);
        check("rst_q", res_q, 0);
        @(negedge clk);
        rst_n = 1;

        // single request
        drive(1, 13, 3, 1);
        drive(0, 0, 0, 1);
        check("s_occ1", occupancy, 1);
        check("s_divx", div_x, 13);
        check("s_divd", div_d, 3);
        check("s_rv0", res_valid, 0);
        drive(0, 0, 0, 1);
        res("s", 4, 1, 0);
        check("s_occ0", occupancy, 0);
        drive(0, 0, 0, 1);
        check("s_drain", res_valid, 0);

        // divide by zero then normal
        drive(1, 9, 0, 1);
        drive(1, 6, 2, 1);
        drive(0, 0, 0, 1);
        res("dz", 4'hF, 9, 1);
        drive(0, 0, 0, 1);
        res("dz2", 3, 0, 0);
        drive(0, 0, 0, 1);

        // backpressure
        drive(1, 15, 4, 0);
        check("bp_rdy1", req_ready, 1);
        drive(1, 7, 7, 0);
        check("bp_rdy2", req_ready, 1);
        drive(1, 8, 3, 0);
        check("bp_rdy3", req_ready, 1);
        drive(1, 5, 1, 0);
        check("bp_rdy4", req_ready, 0);
        check("bp_occ", occupancy, 2);
        res("bp0", 3, 3, 0);
        drive(1, 5, 1, 0);
        check("bp_hold", res_q, 3);
        drive(1, 5, 1, 1);
        check("bp_rdy5", req_ready, 0);
        drive(1, 5, 1, 1);
        res("bp1", 1, 0, 0);
        check("bp_rdy6", req_ready, 1);
        drive(0, 0, 0, 1);
        res("bp2", 2, 2, 0);
        drive(0, 0, 0, 1);
        res("bp3", 5, 0, 0);
        check("bp_occ0", occupancy, 0);
        drive(0, 0, 0, 1);

        // streaming
        for (int i = 0; i < 18; i++) begin
            drive(i < 16, 4'(i), 4'((i % 5) + 1), 1);
            check("st_occ", {31'd0, occupancy <= 2'd1}, 1);
            if (i >= 2) begin
                res("st", 4'((i - 2) / (((i - 2) % 5) + 1)),
                    4'((i - 2) % (((i - 2) % 5) + 1)), 0);
            end
        end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("st_end", res_valid, 0);

        // full with push+pop requested: pointers wrap, order preserved
        fill(12, 5);
        check("f_occ", occupancy, 2);
        res("f0", 2, 2, 0);
        drive(1, 9, 4, 1);
        check("f_rdy", req_ready, 0);
        drive(1, 9, 4, 1);
        res("f1", 3, 1, 0);
        check("f_occ1", occupancy, 1);
        drive(1, 14, 3, 1);
        res("f2", 5, 1, 0);
        check("f_occ2", occupancy, 1);
        drive(0, 0, 0, 1);
        res("f3", 2, 1, 0);
        drive(0, 0, 0, 1);
        res("f4", 4, 2, 0);
        check("f_occ0", occupancy, 0);
        drive(0, 0, 0, 1);

        // clr with an in-flight push dropped
        fill(9, 0);
        check("c_dz", res_dz, 1);
        check("c_occ", occupancy, 2);
        drive(0, 0, 0, 0);
        clr = 1;
        req_valid = 1; req_x = 3; req_d = 1;
        drive(0, 0, 0, 0);
        clr = 0;
        check("c_rv", res_valid, 0);
        check("c_occ0", occupancy, 0);
        check("c_dz0", res_dz, 0);
        check("c_divx", div_x, 0);
        check("c_rdy", req_ready, 1);

        // asynchronous reset between edges
        fill(12, 5);
        check("r_rv1", res_valid, 1);
        #2 rst_n = 0;
        #1;
        check("r_rv", res_valid, 0);
        check("r_occ", occupancy, 0);
        check("r_q", res_q, 0);
        check("r_r", res_r, 0);
        check("r_divx", div_x, 0);
        check("r_rdy", req_ready, 1);
        @(negedge clk);
        rst_n = 1;
        drive(1, 13, 3, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        res("r_post", 4, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
